regfile_sb: RTL and testbench

- Parametrised successor to the CPU's general-purpose register file.
- Provides NRD combinational read ports with write-to-read bypass, one synchronous write port, and an optional hardwired-zero register.
- Adds a per-register pending-write scoreboard with a live busy count, plus a registered debug read port.
- Sits between decode (reads, reservations) and writeback (writes) in the MIPS pipeline; the hazard unit consumes rd_busy and busy_cnt.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_sb_if.sv | 37 +++
 rtl/regfile_scoreboard.sv | 63 ++++++
 rtl/regfile_sb.sv | 89 ++++++++
 tb/tb_regfile_sb.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for the register file slice.
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width.
//   popcount_delta          : net change of the busy population in one cycle.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  // +1 when a clear bit becomes set, -1 when a set bit is cleared; both
  // may happen in the same cycle on different registers and cancel out.
  function automatic logic signed [1:0] popcount_delta(input logic set_new,
                                                       input logic clr_old);
    logic signed [1:0] d;
    d = 2'sd0;
    if (set_new) d = d + 2'sd1;
    if (clr_old) d = d - 2'sd1;
    return d;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback-facing bus of the register file.
//   rd_addr/rd_data/rd_busy : NRD combinational read ports with busy flags.
//   wr_en/wr_addr/wr_data   : synchronous write port.
//   resv_en/resv_addr/flush : scoreboard reservation and clear.
//   busy_cnt                : registered number of busy registers.
//   dbg_addr/dbg_data       : registered debug read port.
// master drives requests (pipeline/bench); slave is the register file.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NRD    = 2
);
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  resv_en;
  logic [ADDR_W-1:0]     resv_addr;
  logic                  flush;
  logic [ADDR_W:0]       busy_cnt;
  logic [ADDR_W-1:0]     dbg_addr;
  logic [DATA_W-1:0]     dbg_data;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, resv_en, resv_addr, flush, dbg_addr,
    input  rd_data, rd_busy, busy_cnt, dbg_data
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, resv_en, resv_addr, flush, dbg_addr,
    output rd_data, rd_busy, busy_cnt, dbg_data
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits and live busy count.
//   clk, reset          : clock, asynchronous active-low reset.
//   resv_en/resv_addr   : mark a destination register pending.
//   wr_en/wr_addr       : writeback completes, clears the pending bit.
//   flush               : clears every pending bit (wins over resv_en).
//   busy                : pending bit per register.
//   busy_cnt            : registered population count of busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned ADDR_W   = ADDR_W_DEF,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned NREGS    = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              resv_en,
  input  logic [ADDR_W-1:0] resv_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              flush,
  output logic [NREGS-1:0]  busy,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             resv_ok, set_new, clr_old;
  logic signed [1:0] delta;
  logic [CNT_W-1:0] delta_ext;

  always_comb begin
    resv_ok = resv_en && !(ZERO_REG != 0 && resv_addr == '0);
    set_new = resv_ok && !busy_q[resv_addr];
    // A write on the register being re-reserved keeps it busy, so it is
    // not a decrement.
    clr_old = wr_en && busy_q[wr_addr] && !(resv_ok && resv_addr == wr_addr);

    busy_d = busy_q;
    if (wr_en)   busy_d[wr_addr]   = 1'b0;
    if (resv_ok) busy_d[resv_addr] = 1'b1;
    if (flush)   busy_d            = '0;

    delta     = popcount_delta(set_new, clr_old);
    delta_ext = {{(CNT_W-2){delta[1]}}, delta};
    busy_cnt_d = flush ? '0 : busy_cnt_q + delta_ext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file with scoreboard.
//   clk, reset : clock, asynchronous active-low reset.
//   bus        : regfile_sb_if slave; NRD combinational read ports with
//                write bypass and busy flags, one synchronous write port,
//                reservation/flush, busy_cnt and a registered debug read.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);
  localparam int unsigned NREGS = 2**ADDR_W;

  logic [DATA_W-1:0]     regs_q [NREGS];
  logic [DATA_W-1:0]     regs_d [NREGS];
  logic [DATA_W-1:0]     dbg_data_q, dbg_data_d;
  logic                  wr_ok;
  logic [NREGS-1:0]      busy;
  logic [ADDR_W:0]       busy_cnt;
  logic [NRD*DATA_W-1:0] rd_data_c;
  logic [NRD-1:0]        rd_busy_c;

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .resv_en  (bus.resv_en),
    .resv_addr(bus.resv_addr),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .flush    (bus.flush),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  always_comb begin
    wr_ok  = bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == '0);
    regs_d = regs_q;
    if (wr_ok) regs_d[bus.wr_addr] = bus.wr_data;
    // Debug port samples stored contents only, never the bypass path.
    dbg_data_d = (ZERO_REG != 0 && bus.dbg_addr == '0) ? '0 : regs_q[bus.dbg_addr];
  end

  always_comb begin : rd_mux
    logic [ADDR_W-1:0] a;
    logic              hit;
    a         = '0;
    hit       = 1'b0;
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      a   = bus.rd_addr[i*ADDR_W +: ADDR_W];
      hit = BYPASS != 0 && bus.wr_en && bus.wr_addr == a;
      if (ZERO_REG != 0 && a == '0)
        rd_data_c[i*DATA_W +: DATA_W] = '0;
      else if (hit)
        rd_data_c[i*DATA_W +: DATA_W] = bus.wr_data;
      else
        rd_data_c[i*DATA_W +: DATA_W] = regs_q[a];
      // Register 0 is never marked busy when hardwired, so no extra gating.
      rd_busy_c[i] = busy[a] && !hit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q     <= '{default: '0};
      dbg_data_q <= '0;
    end else begin
      regs_q     <= regs_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_busy  = rd_busy_c;
  assign bus.busy_cnt = busy_cnt;
  assign bus.dbg_data = dbg_data_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed table-driven bench for regfile_sb, with a second
// BYPASS=0 instance fed the same stimulus.
module tb_regfile_sb;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bus ();
  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) nb ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk  (clk),
    .reset(reset),
    .bus  (nb)
  );

  assign nb.rd_addr   = bus.rd_addr;
  assign nb.wr_en     = bus.wr_en;
  assign nb.wr_addr   = bus.wr_addr;
  assign nb.wr_data   = bus.wr_data;
  assign nb.resv_en   = bus.resv_en;
  assign nb.resv_addr = bus.resv_addr;
  assign nb.flush     = bus.flush;
  assign nb.dbg_addr  = bus.dbg_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic        fl;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [4:0]  da;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic [31:0] e_nb1;
    logic [1:0]  e_bsy;
    logic [5:0]  e_cnt;
    logic [31:0] e_dbg;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd,
                              logic re, logic [4:0] ra, logic fl,
                              logic [4:0] a0, logic [4:0] a1, logic [4:0] da,
                              logic [31:0] e_d0, logic [31:0] e_d1, logic [31:0] e_nb1,
                              logic [1:0] e_bsy, logic [5:0] e_cnt, logic [31:0] e_dbg);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.fl = fl;
    v.a0 = a0; v.a1 = a1; v.da = da;
    v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_nb1 = e_nb1;
    v.e_bsy = e_bsy; v.e_cnt = e_cnt; v.e_dbg = e_dbg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.resv_en   = 1'b0;
    bus.resv_addr = '0;
    bus.flush     = 1'b0;
    bus.rd_addr   = '0;
    bus.dbg_addr  = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive_idle();

    // Vectors: each is driven after a falling edge and checked before the
    // next rising edge; registered outputs reflect earlier vectors.
    //            we    wa     wd            re    ra     fl    a0     a1     da       e_d0          e_d1          e_nb1         bsy    cnt    dbg
    vq.push_back(mk(1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd5,  5'd5,  5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        2'b00, 6'd0, 32'h0));
    vq.push_back(mk(1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  1'b0, 5'd5,  5'd0,  5'd5,  32'hDEADBEEF, 32'h0,        32'h0,        2'b00, 6'd0, 32'h0));
    vq.push_back(mk(1'b1, 5'd7,  32'hA5A5A5A5, 1'b0, 5'd0,  1'b0, 5'd0,  5'd7,  5'd0,  32'h0,        32'hA5A5A5A5, 32'h0,        2'b00, 6'd0, 32'hDEADBEEF));
    vq.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd5,  5'd7,  5'd7,  32'hDEADBEEF, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 6'd0, 32'h0));
    vq.push_back(mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  5'd9,  5'd0,  32'h0,        32'h0,        32'h0,        2'b00, 6'd0, 32'hA5A5A5A5));
    vq.push_back(mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd3,  5'd9,  5'd0,  32'h0,        32'h0,        32'h0,        2'b01, 6'd1, 32'h0));
    vq.push_back(mk(1'b1, 5'd3,  32'h11111111, 1'b0, 5'd0,  1'b0, 5'd3,  5'd9,  5'd0,  32'h11111111, 32'h0,        32'h0,        2'b10, 6'd2, 32'h0));
    vq.push_back(mk(1'b1, 5'd9,  32'h22222222, 1'b1, 5'd9,  1'b0, 5'd3,  5'd9,  5'd0,  32'h11111111, 32'h22222222, 32'h0,        2'b00, 6'd1, 32'h0));
    vq.push_back(mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b0, 5'd0,  5'd9,  5'd0,  32'h0,        32'h22222222, 32'h22222222, 2'b10, 6'd1, 32'h0));
    vq.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd9,  5'd0,  32'h0,        32'h22222222, 32'h22222222, 2'b10, 6'd1, 32'h0));
    vq.push_back(mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  1'b0, 5'd1,  5'd2,  5'd0,  32'h0,        32'h0,        32'h0,        2'b00, 6'd1, 32'h0));
    vq.push_back(mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  1'b0, 5'd1,  5'd2,  5'd0,  32'h0,        32'h0,        32'h0,        2'b01, 6'd2, 32'h0));
    vq.push_back(mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  1'b0, 5'd4,  5'd2,  5'd0,  32'h0,        32'h0,        32'h0,        2'b10, 6'd3, 32'h0));
    vq.push_back(mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  1'b1, 5'd1,  5'd6,  5'd0,  32'h0,        32'h0,        32'h0,        2'b01, 6'd4, 32'h0));
    vq.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd1,  5'd6,  5'd0,  32'h0,        32'h0,        32'h0,        2'b00, 6'd0, 32'h0));
    vq.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd2,  5'd9,  5'd0,  32'h0,        32'h22222222, 32'h22222222, 2'b00, 6'd0, 32'h0));
    vq.push_back(mk(1'b1, 5'd2,  32'h33333333, 1'b0, 5'd0,  1'b0, 5'd2,  5'd4,  5'd2,  32'h33333333, 32'h0,        32'h0,        2'b00, 6'd0, 32'h0));
    vq.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd2,  5'd2,  5'd2,  32'h33333333, 32'h33333333, 32'h33333333, 2'b00, 6'd0, 32'h0));
    vq.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        2'b00, 6'd0, 32'h33333333));

    // Reset held with random activity on every input.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.wr_en     = 1'($urandom);
      bus.wr_addr   = 5'($urandom);
      bus.wr_data   = $urandom;
      bus.resv_en   = 1'($urandom);
      bus.resv_addr = 5'($urandom);
      bus.flush     = 1'($urandom);
      bus.rd_addr   = 10'($urandom);
      bus.dbg_addr  = 5'($urandom);
    end
    #2;
    chk("rst_busy_cnt", 32'(bus.busy_cnt), 32'h0);
    chk("rst_dbg", bus.dbg_data, 32'h0);

    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus.rd_addr = {5'(2*k+1), 5'(2*k)};
      #2;
      chk("rst_rd0", bus.rd_data[31:0], 32'h0);
      chk("rst_rd1", bus.rd_data[63:32], 32'h0);
    end
    chk("rst_cnt_after", 32'(bus.busy_cnt), 32'h0);
    chk("rst_dbg_after", bus.dbg_data, 32'h0);

    foreach (vq[i]) begin
      @(negedge clk);
      bus.wr_en     = vq[i].we;
      bus.wr_addr   = vq[i].wa;
      bus.wr_data   = vq[i].wd;
      bus.resv_en   = vq[i].re;
      bus.resv_addr = vq[i].ra;
      bus.flush     = vq[i].fl;
      bus.rd_addr   = {vq[i].a1, vq[i].a0};
      bus.dbg_addr  = vq[i].da;
      #2;
      chk($sformatf("v%0d_rd0", i), bus.rd_data[31:0], vq[i].e_d0);
      chk($sformatf("v%0d_rd1", i), bus.rd_data[63:32], vq[i].e_d1);
      chk($sformatf("v%0d_nb_rd1", i), nb.rd_data[63:32], vq[i].e_nb1);
      chk($sformatf("v%0d_busy", i), 32'(bus.rd_busy), 32'(vq[i].e_bsy));
      chk($sformatf("v%0d_cnt", i), 32'(bus.busy_cnt), 32'(vq[i].e_cnt));
      chk($sformatf("v%0d_dbg", i), bus.dbg_data, vq[i].e_dbg);
    end

    // Debug latency, then asynchronous reset between edges.
    @(negedge clk);
    drive_idle();
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 5'd12;
    bus.wr_data   = 32'h0000CAFE;
    bus.resv_en   = 1'b1;
    bus.resv_addr = 5'd20;
    bus.dbg_addr  = 5'd12;
    bus.rd_addr   = {5'd0, 5'd12};
    #2;
    chk("cafe_bypass", bus.rd_data[31:0], 32'h0000CAFE);
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.resv_en = 1'b0;
    #2;
    chk("dbg_prewrite", bus.dbg_data, 32'h0);
    chk("cnt_r20", 32'(bus.busy_cnt), 32'h1);
    @(negedge clk);
    #2;
    chk("dbg_cafe", bus.dbg_data, 32'h0000CAFE);
    #1 reset = 1'b0;
    #1;
    chk("async_dbg", bus.dbg_data, 32'h0);
    chk("async_cnt", 32'(bus.busy_cnt), 32'h0);
    chk("async_rd", bus.rd_data[31:0], 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #2;
    chk("post_rst_dbg", bus.dbg_data, 32'h0);
    chk("post_rst_rd", bus.rd_data[31:0], 32'h0);
    chk("post_rst_cnt", 32'(bus.busy_cnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
